control_r: RTL and testbench

CONTROL_R -- requirements
Module: control_r

---
 rtl/control_r_if.sv | 47 ++++
 rtl/control_r.sv | 178 +++++++++++++++++
 tb/tb_control_r.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_r_if.sv
//==============================================================================
// Module      : control_r_if
// Description : PHY-side receive beat stream plus token/handshake (ro) and
//               data (rl) output streams and status pulses of control_r.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface control_r_if;
    logic       rx_data_on;
    logic       rx_pl_sop;
    logic       rx_pl_eop;
    logic       rx_pl_valid;
    logic       rx_pl_ready;
    logic [7:0] rx_pl_data;
    logic       rx_ro_sop;
    logic       rx_ro_eop;
    logic       rx_ro_valid;
    logic       rx_ro_ready;
    logic [7:0] rx_ro_data;
    logic       rx_rl_sop;
    logic       rx_rl_eop;
    logic       rx_rl_valid;
    logic       rx_rl_ready;
    logic [7:0] rx_rl_data;
    logic       rx_rl_cancle;
    logic       rx_pid_err;
    logic       rx_drop;

    modport slave (
        input  rx_data_on, rx_pl_sop, rx_pl_eop, rx_pl_valid, rx_pl_data,
               rx_ro_ready, rx_rl_ready,
        output rx_pl_ready, rx_ro_sop, rx_ro_eop, rx_ro_valid, rx_ro_data,
               rx_rl_sop, rx_rl_eop, rx_rl_valid, rx_rl_data,
               rx_rl_cancle, rx_pid_err, rx_drop
    );

    modport master (
        output rx_data_on, rx_pl_sop, rx_pl_eop, rx_pl_valid, rx_pl_data,
               rx_ro_ready, rx_rl_ready,
        input  rx_pl_ready, rx_ro_sop, rx_ro_eop, rx_ro_valid, rx_ro_data,
               rx_rl_sop, rx_rl_eop, rx_rl_valid, rx_rl_data,
               rx_rl_cancle, rx_pid_err, rx_drop
    );
endinterface

`default_nettype wire

// File: rtl/control_r.sv
//==============================================================================
// Module      : control_r
// Description : Receive packet router: PID-classifies PHY packets onto the
//               token/handshake (ro) or data (rl) path, drops the rest.
//               Optional macro CTRL_R_PID_CHECK_EN enables PID complement check.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_r (
    input  wire        clk,
    input  wire        rst,
    control_r_if.slave bus
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_tok  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;
    localparam logic [1:0] c_st_drop = 2'd3;

    localparam logic [1:0] c_pid_rsvd  = 2'b00;
    localparam logic [1:0] c_pid_token = 2'b01;
    localparam logic [1:0] c_pid_hand  = 2'b10;
    localparam logic [1:0] c_pid_data  = 2'b11;

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_rdy_en;

    logic       r_ro_valid, r_ro_sop, r_ro_eop;
    logic [7:0] r_ro_data;
    logic       r_rl_valid, r_rl_sop, r_rl_eop;
    logic [7:0] r_rl_data;
    logic       r_drop, r_cancel, r_pid_err;

    logic       w_ro_free, w_rl_free, w_pl_ready, w_accept, w_pid_ok;
    logic       w_fwd_ro, w_fwd_rl, w_fwd_sop;
    logic       w_drop, w_cancel, w_pid_err;

    assign w_ro_free = !r_ro_valid || bus.rx_ro_ready;
    assign w_rl_free = !r_rl_valid || bus.rx_rl_ready;

    // In IDLE the destination is unknown until the PID is seen, so both must have room
    always_comb begin
        w_pl_ready = 1'b0;
        case (r_state)
            c_st_idle: w_pl_ready = w_ro_free && w_rl_free;
            c_st_tok:  w_pl_ready = w_ro_free;
            c_st_data: w_pl_ready = w_rl_free;
            default:   w_pl_ready = 1'b1;
        endcase
        w_pl_ready = w_pl_ready && r_rdy_en;
    end

    assign w_accept = bus.rx_pl_valid && w_pl_ready;

`ifdef CTRL_R_PID_CHECK_EN
    assign w_pid_ok = (bus.rx_pl_data[3:0] == ~bus.rx_pl_data[7:4]);
`else
    assign w_pid_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_fwd_ro     = 1'b0;
        w_fwd_rl     = 1'b0;
        w_fwd_sop    = (r_state == c_st_idle);
        w_drop       = 1'b0;
        w_cancel     = 1'b0;
        w_pid_err    = 1'b0;
        if (w_accept) begin
            case (r_state)
                c_st_idle: begin
                    if (bus.rx_pl_sop) begin
                        w_next_state = bus.rx_pl_eop ? c_st_idle : c_st_drop;
                        if (!w_pid_ok) begin
                            w_pid_err = 1'b1;
                        end else begin
                            case (bus.rx_pl_data[1:0])
                                c_pid_token, c_pid_hand: begin
                                    w_fwd_ro     = 1'b1;
                                    w_next_state = bus.rx_pl_eop ? c_st_idle : c_st_tok;
                                end
                                c_pid_data: begin
                                    if (bus.rx_data_on) begin
                                        w_fwd_rl     = 1'b1;
                                        w_next_state = bus.rx_pl_eop ? c_st_idle : c_st_data;
                                    end else begin
                                        w_drop = 1'b1;
                                    end
                                end
                                c_pid_rsvd: w_drop = 1'b1;
                                default:    w_drop = 1'b1;
                            endcase
                        end
                    end
                end
                c_st_tok, c_st_data: begin
                    // A fresh SOP truncates the open packet; the new packet is discarded whole
                    if (bus.rx_pl_sop) begin
                        w_drop       = 1'b1;
                        w_cancel     = (r_state == c_st_data);
                        w_next_state = bus.rx_pl_eop ? c_st_idle : c_st_drop;
                    end else begin
                        w_fwd_ro = (r_state == c_st_tok);
                        w_fwd_rl = (r_state == c_st_data);
                        if (bus.rx_pl_eop) w_next_state = c_st_idle;
                    end
                end
                default: begin
                    if (bus.rx_pl_eop) w_next_state = c_st_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ro_valid <= 1'b0;
            r_ro_sop   <= 1'b0;
            r_ro_eop   <= 1'b0;
            r_ro_data  <= 8'h00;
            r_rl_valid <= 1'b0;
            r_rl_sop   <= 1'b0;
            r_rl_eop   <= 1'b0;
            r_rl_data  <= 8'h00;
            r_drop     <= 1'b0;
            r_cancel   <= 1'b0;
            r_pid_err  <= 1'b0;
        end else begin
            if (w_ro_free) begin
                r_ro_valid <= w_fwd_ro;
                if (w_fwd_ro) begin
                    r_ro_sop  <= w_fwd_sop;
                    r_ro_eop  <= bus.rx_pl_eop;
                    r_ro_data <= bus.rx_pl_data;
                end
            end
            if (w_rl_free) begin
                r_rl_valid <= w_fwd_rl;
                if (w_fwd_rl) begin
                    r_rl_sop  <= w_fwd_sop;
                    r_rl_eop  <= bus.rx_pl_eop;
                    r_rl_data <= bus.rx_pl_data;
                end
            end
            r_drop    <= w_drop;
            r_cancel  <= w_cancel;
            r_pid_err <= w_pid_err;
        end
    end

    assign bus.rx_pl_ready  = w_pl_ready;
    assign bus.rx_ro_valid  = r_ro_valid;
    assign bus.rx_ro_sop    = r_ro_sop;
    assign bus.rx_ro_eop    = r_ro_eop;
    assign bus.rx_ro_data   = r_ro_data;
    assign bus.rx_rl_valid  = r_rl_valid;
    assign bus.rx_rl_sop    = r_rl_sop;
    assign bus.rx_rl_eop    = r_rl_eop;
    assign bus.rx_rl_data   = r_rl_data;
    assign bus.rx_drop      = r_drop;
    assign bus.rx_rl_cancle = r_cancel;
    assign bus.rx_pid_err   = r_pid_err;

endmodule

`default_nettype wire

// File: tb/tb_control_r.sv
//==============================================================================
// Module      : tb_control_r
// Description : Table-driven self-checking bench for control_r.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_r;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    control_r_if bus ();

    control_r dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       vld, sop, eop;
        logic [7:0] d;
        logic       don, ror, rlr;
        logic       e_rdy;
        logic       e_rov, e_ros, e_roe;
        logic [7:0] e_rod;
        logic       e_rlv, e_rls, e_rle;
        logic [7:0] e_rld;
        logic       e_drop, e_can, e_pid;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(
        input logic vld, input logic sop, input logic eop, input logic [7:0] d,
        input logic don, input logic ror, input logic rlr, input logic rdy,
        input logic rov, input logic ros, input logic roe, input logic [7:0] rod,
        input logic rlv, input logic rls, input logic rle, input logic [7:0] rld,
        input logic drp, input logic can, input logic pid);
        vec_t v;
        v.vld = vld; v.sop = sop; v.eop = eop; v.d = d;
        v.don = don; v.ror = ror; v.rlr = rlr; v.e_rdy = rdy;
        v.e_rov = rov; v.e_ros = ros; v.e_roe = roe; v.e_rod = rod;
        v.e_rlv = rlv; v.e_rls = rls; v.e_rle = rle; v.e_rld = rld;
        v.e_drop = drp; v.e_can = can; v.e_pid = pid;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic sop, input logic eop, input logic [7:0] d);
        bus.rx_pl_valid = vld;
        bus.rx_pl_sop   = sop;
        bus.rx_pl_eop   = eop;
        bus.rx_pl_data  = d;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ro_valid"}, {7'd0, bus.rx_ro_valid}, 8'd0);
        chk({tag, " ro_data"},  bus.rx_ro_data, 8'h00);
        chk({tag, " rl_valid"}, {7'd0, bus.rx_rl_valid}, 8'd0);
        chk({tag, " rl_sop"},   {7'd0, bus.rx_rl_sop}, 8'd0);
        chk({tag, " rl_data"},  bus.rx_rl_data, 8'h00);
        chk({tag, " pulses"},   {5'd0, bus.rx_drop, bus.rx_rl_cancle, bus.rx_pid_err}, 8'd0);
        chk({tag, " pl_ready"}, {7'd0, bus.rx_pl_ready}, 8'd0);
    endtask

    initial begin
        logic [7:0] pkt [12];
        int idx, got, cyc;
        logic acc, hs, hs_sop, hs_eop;
        logic [7:0] hs_d;

        // Table: pre-edge ready, then registered outputs after the edge
        vecs[0]  = mk(1,1,0,8'hE1, 1,1,1, 1, 1,1,0,8'hE1, 0,0,0,8'h00, 0,0,0);
        vecs[1]  = mk(1,0,0,8'h08, 1,1,1, 1, 1,0,0,8'h08, 0,0,0,8'h00, 0,0,0);
        vecs[2]  = mk(1,0,1,8'h58, 1,1,1, 1, 1,0,1,8'h58, 0,0,0,8'h00, 0,0,0);
        vecs[3]  = mk(0,0,0,8'h00, 1,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,0);
        vecs[4]  = mk(1,0,0,8'h55, 1,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,0);
`ifdef CTRL_R_PID_CHECK_EN
        vecs[5]  = mk(1,1,1,8'hE2, 1,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,1);
`else
        vecs[5]  = mk(1,1,1,8'hE2, 1,1,1, 1, 1,1,1,8'hE2, 0,0,0,8'h00, 0,0,0);
`endif
        vecs[6]  = mk(1,1,0,8'hC3, 0,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 1,0,0);
        vecs[7]  = mk(1,0,0,8'h01, 0,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,0);
        vecs[8]  = mk(1,0,1,8'h02, 0,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,0);
        vecs[9]  = mk(1,1,1,8'hF0, 1,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 1,0,0);
        vecs[10] = mk(1,1,0,8'hC3, 1,1,1, 1, 0,0,0,8'h00, 1,1,0,8'hC3, 0,0,0);
        vecs[11] = mk(1,0,0,8'h11, 0,1,1, 1, 0,0,0,8'h00, 1,0,0,8'h11, 0,0,0);
        vecs[12] = mk(1,1,0,8'hD2, 1,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 1,1,0);
        vecs[13] = mk(1,0,1,8'h77, 1,1,1, 1, 0,0,0,8'h00, 0,0,0,8'h00, 0,0,0);
        vecs[14] = mk(1,1,0,8'hC3, 1,1,1, 1, 0,0,0,8'h00, 1,1,0,8'hC3, 0,0,0);
        vecs[15] = mk(1,0,1,8'hAA, 1,1,1, 1, 0,0,0,8'h00, 1,0,1,8'hAA, 0,0,0);
        vecs[16] = mk(1,1,1,8'hE1, 1,0,1, 1, 1,1,1,8'hE1, 0,0,0,8'h00, 0,0,0);
        vecs[17] = mk(1,1,0,8'hC3, 1,0,1, 0, 1,1,1,8'hE1, 0,0,0,8'h00, 0,0,0);
        vecs[18] = mk(1,1,0,8'hC3, 1,1,1, 1, 0,0,0,8'h00, 1,1,0,8'hC3, 0,0,0);
        vecs[19] = mk(1,0,1,8'hEE, 1,1,1, 1, 0,0,0,8'h00, 1,0,1,8'hEE, 0,0,0);

        pkt[0] = 8'hC3;
        for (int k = 1; k <= 10; k++) pkt[k] = 8'(k);
        pkt[11] = 8'h5A;

        // Reset state
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        bus.rx_data_on  = 1'b0;
        bus.rx_ro_ready = 1'b1;
        bus.rx_rl_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("reset pl_ready after release", {7'd0, bus.rx_pl_ready}, 8'd1);

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].vld, vecs[i].sop, vecs[i].eop, vecs[i].d);
            bus.rx_data_on  = vecs[i].don;
            bus.rx_ro_ready = vecs[i].ror;
            bus.rx_rl_ready = vecs[i].rlr;
            #1;
            chk($sformatf("v%0d pl_ready", i), {7'd0, bus.rx_pl_ready}, {7'd0, vecs[i].e_rdy});
            @(posedge clk); #1;
            chk($sformatf("v%0d ro_valid", i), {7'd0, bus.rx_ro_valid}, {7'd0, vecs[i].e_rov});
            if (vecs[i].e_rov)
                chk($sformatf("v%0d ro_sop_eop_data", i),
                    {bus.rx_ro_sop, bus.rx_ro_eop, bus.rx_ro_data[5:0]},
                    {vecs[i].e_ros, vecs[i].e_roe, vecs[i].e_rod[5:0]});
            if (vecs[i].e_rov)
                chk($sformatf("v%0d ro_data", i), bus.rx_ro_data, vecs[i].e_rod);
            chk($sformatf("v%0d rl_valid", i), {7'd0, bus.rx_rl_valid}, {7'd0, vecs[i].e_rlv});
            if (vecs[i].e_rlv) begin
                chk($sformatf("v%0d rl_sop_eop", i), {6'd0, bus.rx_rl_sop, bus.rx_rl_eop},
                    {6'd0, vecs[i].e_rls, vecs[i].e_rle});
                chk($sformatf("v%0d rl_data", i), bus.rx_rl_data, vecs[i].e_rld);
            end
            chk($sformatf("v%0d drop", i),   {7'd0, bus.rx_drop},      {7'd0, vecs[i].e_drop});
            chk($sformatf("v%0d cancel", i), {7'd0, bus.rx_rl_cancle}, {7'd0, vecs[i].e_can});
            chk($sformatf("v%0d pid_err", i), {7'd0, bus.rx_pid_err},  {7'd0, vecs[i].e_pid});
        end

        // Drain before the streaming sequence
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;

        // 12-byte data packet with throttled link-layer ready
        bus.rx_data_on  = 1'b1;
        bus.rx_ro_ready = 1'b1;
        idx = 0; got = 0; cyc = 0;
        while (got < 12 && cyc < 300) begin
            bus.rx_rl_ready = (cyc % 3 == 0);
            if (idx < 12) drive(1'b1, idx == 0, idx == 11, pkt[idx]);
            else          drive(1'b0, 1'b0, 1'b0, 8'h00);
            #1;
            if (bus.rx_rl_valid && !bus.rx_rl_ready && idx > 0 && idx < 12)
                chk($sformatf("stream pl_ready held c%0d", cyc), {7'd0, bus.rx_pl_ready}, 8'd0);
            if (bus.rx_ro_valid)
                chk($sformatf("stream ro_valid c%0d", cyc), 8'd1, 8'd0);
            acc    = bus.rx_pl_valid && bus.rx_pl_ready;
            hs     = bus.rx_rl_valid && bus.rx_rl_ready;
            hs_d   = bus.rx_rl_data;
            hs_sop = bus.rx_rl_sop;
            hs_eop = bus.rx_rl_eop;
            @(posedge clk); #1;
            if (acc) idx++;
            if (hs) begin
                chk($sformatf("stream byte%0d data", got), hs_d, pkt[got]);
                chk($sformatf("stream byte%0d sop_eop", got), {6'd0, hs_sop, hs_eop},
                    {6'd0, got == 0, got == 11});
                got++;
            end
            cyc++;
        end
        chk("stream bytes received", 8'(got), 8'd12);
        chk("stream rl_valid after end", {7'd0, bus.rx_rl_valid}, 8'd0);

        // Reset while a data beat is held on rl
        bus.rx_rl_ready = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 8'hC3);
        @(posedge clk); #1;
        chk("rst-mid rl_valid before", {7'd0, bus.rx_rl_valid}, 8'd1);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 8'h22);
        @(posedge clk); #1;
        chk_all_zero("rst-mid");
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;
        chk("rst-mid pl_ready after release", {7'd0, bus.rx_pl_ready}, 8'd1);
        bus.rx_rl_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 8'hE1);
        @(posedge clk); #1;
        chk("rst-mid next token ro", {5'd0, bus.rx_ro_valid, bus.rx_ro_sop, bus.rx_ro_eop}, 8'd7);
        chk("rst-mid next token data", bus.rx_ro_data, 8'hE1);
        chk("rst-mid no cancel", {6'd0, bus.rx_rl_cancle, bus.rx_drop}, 8'd0);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
